id_operand_stage: RTL and testbench

- Parametrised operand-fetch and bypass stage placed between instruction decode and EX.
- Takes one decoded request per cycle, drives register-file read addresses and resolves each source operand from NUM_FWD prioritised bypass sources, the register file or the immediate.
- Detects load-use hazards from pending bypass sources and stalls.
- Holds the result in a registered ID/EX slot with a valid/ready handshake and synchronous flush.

---
 rtl/id_operand_stage.sv | 169 ++++++++++++++++
 tb/tb_id_operand_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ============================================================================
// Module   : id_operand_stage
// Brief    : Operand-fetch / bypass stage between decode and EX. Resolves two
//            source operands from prioritised bypass sources, the register
//            file or the immediate, detects load-use hazards, and holds the
//            result in a registered ID/EX slot with valid/ready handshake.
// Options  : ID_PERF_CNT_EN - adds saturating stall / flush performance
//            counters (ports perf_stall_cnt, perf_flush_cnt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3,
    parameter int OP_W    = 8
`ifdef ID_PERF_CNT_EN
    ,parameter int CNT_W  = 32
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OP_W-1:0]             in_op,
    input  logic [1:0]                  in_src_en,
    input  logic [2*REG_AW-1:0]         in_src_addr,
    input  logic [DATA_W-1:0]           in_imm,
    input  logic                        in_dst_en,
    input  logic [REG_AW-1:0]           in_dst_addr,
    output logic [2*REG_AW-1:0]         rf_raddr,
    input  logic [2*DATA_W-1:0]         rf_rdata,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD-1:0]          fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0]   fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_W-1:0]             out_op,
    output logic [DATA_W-1:0]           out_opnd1,
    output logic [DATA_W-1:0]           out_opnd2,
    output logic                        out_dst_en,
    output logic [REG_AW-1:0]           out_dst_addr,
    output logic                        stall_o
`ifdef ID_PERF_CNT_EN
    ,output logic [CNT_W-1:0]           perf_stall_cnt,
    output logic [CNT_W-1:0]            perf_flush_cnt
`endif
);

    logic [2*DATA_W-1:0] w_opnd;
    logic [1:0]          w_haz;
    logic                w_accept;

    logic                r_valid;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_opnd1;
    logic [DATA_W-1:0]   r_opnd2;
    logic                r_dst_en;
    logic [REG_AW-1:0]   r_dst_addr;

    // Register file is addressed directly from the decoded source fields
    assign rf_raddr = in_src_addr;

    for (genvar k = 0; k < 2; k++) begin : g_opnd
        logic [REG_AW-1:0] w_addr;
        logic              w_hit;
        logic              w_pend;
        logic [DATA_W-1:0] w_fdata;
        logic [DATA_W-1:0] w_val;
        logic              w_haz_k;

        assign w_addr = in_src_addr[k*REG_AW +: REG_AW];

        // Scan from oldest to youngest so the lowest matching index wins
        always_comb begin
            w_hit   = 1'b0;
            w_pend  = 1'b0;
            w_fdata = '0;
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == w_addr)) begin
                    w_hit   = 1'b1;
                    w_pend  = fwd_pending[i];
                    w_fdata = fwd_data[i*DATA_W +: DATA_W];
                end
            end
        end

        // Select immediate, zero register, bypass or register-file data
        always_comb begin
            w_val   = rf_rdata[k*DATA_W +: DATA_W];
            w_haz_k = 1'b0;
            if (!in_src_en[k]) begin
                w_val = in_imm;
            end else if (w_addr == '0) begin
                w_val = '0;
            end else if (w_hit) begin
                // A pending winner stalls; its data value is irrelevant then
                w_haz_k = w_pend;
                w_val   = w_fdata;
            end
        end

        assign w_opnd[k*DATA_W +: DATA_W] = w_val;
        assign w_haz[k]                   = w_haz_k;
    end

    assign stall_o  = in_valid & (|w_haz);
    assign in_ready = ~flush & ~stall_o & (~r_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    // ID/EX slot: flush beats accept beats drain; payload moves only on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_op       <= '0;
            r_opnd1    <= '0;
            r_opnd2    <= '0;
            r_dst_en   <= 1'b0;
            r_dst_addr <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_op       <= in_op;
            r_opnd1    <= w_opnd[0 +: DATA_W];
            r_opnd2    <= w_opnd[DATA_W +: DATA_W];
            r_dst_en   <= in_dst_en;
            r_dst_addr <= in_dst_addr;
        end else if (out_ready) begin
            r_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_op       = r_op;
    assign out_opnd1    = r_opnd1;
    assign out_opnd2    = r_opnd2;
    assign out_dst_en   = r_dst_en;
    assign out_dst_addr = r_dst_addr;

`ifdef ID_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters: unflushed stall cycles, flushes of a live slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o && !flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && r_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none

module tb_id_operand_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 3;
    localparam int OW = 8;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [OW-1:0]     in_op;
    logic [1:0]        in_src_en;
    logic [2*AW-1:0]   in_src_addr;
    logic [DW-1:0]     in_imm;
    logic              in_dst_en;
    logic [AW-1:0]     in_dst_addr;
    logic [2*AW-1:0]   rf_raddr;
    logic [2*DW-1:0]   rf_rdata;
    logic [NF-1:0]     fwd_valid;
    logic [NF-1:0]     fwd_pending;
    logic [NF*AW-1:0]  fwd_addr;
    logic [NF*DW-1:0]  fwd_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_op;
    logic [DW-1:0]     out_opnd1;
    logic [DW-1:0]     out_opnd2;
    logic              out_dst_en;
    logic [AW-1:0]     out_dst_addr;
    logic              stall_o;
`ifdef ID_PERF_CNT_EN
    logic [CW-1:0]     perf_stall_cnt;
    logic [CW-1:0]     perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    id_operand_stage #(
        .DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .OP_W(OW)
`ifdef ID_PERF_CNT_EN
        ,.CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src_en(in_src_en), .in_src_addr(in_src_addr), .in_imm(in_imm),
        .in_dst_en(in_dst_en), .in_dst_addr(in_dst_addr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_opnd1(out_opnd1), .out_opnd2(out_opnd2),
        .out_dst_en(out_dst_en), .out_dst_addr(out_dst_addr),
        .stall_o(stall_o)
`ifdef ID_PERF_CNT_EN
        ,.perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Abstract stimulus view: per-operand and per-bypass-source records
    bit          sen [2];
    int          sa  [2];
    logic [31:0] rf  [2];
    bit          fv  [NF];
    bit          fp  [NF];
    int          fa  [NF];
    logic [31:0] fd  [NF];

    // Reference slot and counters
    bit          m_valid;
    logic [31:0] m_op, m_o1, m_o2, m_da;
    bit          m_de;
    longint      m_sc, m_fc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        in_src_en = {sen[1], sen[0]};
        for (int k = 0; k < 2; k++) begin
            in_src_addr[k*AW +: AW] = AW'(sa[k]);
            rf_rdata[k*DW +: DW]    = rf[k];
        end
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]          = fv[i];
            fwd_pending[i]        = fp[i];
            fwd_addr[i*AW +: AW]  = AW'(sa_wrap(fa[i]));
            fwd_data[i*DW +: DW]  = fd[i];
        end
    endtask

    function automatic int sa_wrap(input int a);
        return a % 32;
    endfunction

    task automatic idle();
        in_valid = 0; in_op = 0; in_imm = 0; in_dst_en = 0; in_dst_addr = 0;
        flush = 0; out_ready = 1;
        for (int k = 0; k < 2; k++) begin sen[k] = 0; sa[k] = 0; rf[k] = 0; end
        for (int i = 0; i < NF; i++) begin fv[i] = 0; fp[i] = 0; fa[i] = 0; fd[i] = 0; end
        pack();
    endtask

    // Operand value from the rules: immediate, r0, first matching bypass, else RF
    function automatic logic [31:0] ref_opnd(input int k, output bit haz);
        haz = 0;
        if (!sen[k]) return in_imm;
        if (sa[k] == 0) return 32'h0;
        for (int i = 0; i < NF; i++) begin
            if (fv[i] && fa[i] == sa[k]) begin
                if (fp[i]) begin haz = 1; return 32'h0; end
                return fd[i];
            end
        end
        return rf[k];
    endfunction

    task automatic chk_out();
        chk("out_valid", out_valid, m_valid);
        chk("out_op", out_op, m_op[OW-1:0]);
        chk("out_opnd1", out_opnd1, m_o1);
        chk("out_opnd2", out_opnd2, m_o2);
        chk("out_dst_en", out_dst_en, m_de);
        chk("out_dst_addr", out_dst_addr, m_da[AW-1:0]);
`ifdef ID_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, m_sc);
        chk("perf_flush_cnt", perf_flush_cnt, m_fc);
`endif
    endtask

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_o1 = 0; m_o2 = 0; m_de = 0; m_da = 0; m_sc = 0; m_fc = 0;
    endtask

    // Apply current stimulus for one clock and check both comb and slot outputs
    task automatic cycle();
        logic [31:0] o0, o1;
        bit h0, h1, e_stall, e_ready;
        pack();
        #1;
        o0 = ref_opnd(0, h0);
        o1 = ref_opnd(1, h1);
        e_stall = in_valid && (h0 || h1);
        e_ready = !flush && !e_stall && (!m_valid || out_ready);
        chk("stall_o", stall_o, e_stall);
        chk("in_ready", in_ready, e_ready);
        chk("rf_raddr", rf_raddr, 64'((sa[1] << AW) | sa[0]));
        if (e_stall && !flush && m_sc < 64'hFFFF_FFFF) m_sc++;
        if (flush && m_valid && m_fc < 64'hFFFF_FFFF) m_fc++;
        if (flush) m_valid = 0;
        else if (in_valid && e_ready) begin
            m_valid = 1; m_op = 32'(in_op); m_o1 = o0; m_o2 = o1;
            m_de = in_dst_en; m_da = 32'(in_dst_addr);
        end else if (out_ready) m_valid = 0;
        @(posedge clk);
        #1;
        chk_out();
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        model_reset();
        chk_out();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        rst = 1;
        idle();
        #2;
        // Reset state
        do_reset();

        // Plain register-file read
        in_valid = 1; in_op = 8'h5A; in_dst_en = 1; in_dst_addr = 5'd9;
        sen[0] = 1; sen[1] = 1; sa[0] = 3; sa[1] = 4; rf[0] = 32'h11; rf[1] = 32'h22;
        cycle();
        chk("plain_opnd1", out_opnd1, 64'h11);
        chk("plain_opnd2", out_opnd2, 64'h22);

        // Bypass priority: youngest matching source wins
        fv[0] = 1; fa[0] = 5; fd[0] = 32'hAAAA;
        fv[2] = 1; fa[2] = 5; fd[2] = 32'hBBBB;
        sa[0] = 5;
        cycle();
        chk("prio_young", out_opnd1, 64'hAAAA);
        fv[0] = 0;
        cycle();
        chk("prio_old", out_opnd1, 64'hBBBB);

        // Load-use hazard then release
        fv[2] = 0; sa[0] = 3;
        fv[0] = 1; fp[0] = 1; fa[0] = 7; sa[1] = 7;
        cycle();
        chk("lu_bubble", out_valid, 64'h0);
        fp[0] = 0; fd[0] = 32'h1234;
        cycle();
        chk("lu_opnd2", out_opnd2, 64'h1234);

        // Pending match at higher index masked by non-pending lower index
        fv[1] = 1; fp[1] = 1; fa[1] = 7;
        cycle();

        // r0 and immediate
        fv[1] = 0; fv[0] = 1; fp[0] = 1; fa[0] = 0;
        sa[0] = 0; sen[1] = 0; in_imm = 32'hFFFF_FFFC;
        cycle();
        chk("r0_opnd1", out_opnd1, 64'h0);
        chk("imm_opnd2", out_opnd2, 64'hFFFF_FFFC);

        // Backpressure: slot held three cycles while new requests wait
        out_ready = 0; in_op = 8'hC3; in_imm = 32'h7777;
        repeat (3) cycle();
        chk("bp_held", out_opnd2, 64'hFFFF_FFFC);
        // Flush with a live request
        flush = 1;
        cycle();
        chk("flush_drop", out_valid, 64'h0);
        flush = 0; out_ready = 1;

        // Performance counter scenario: four stalls, then flush of a live slot
        idle();
        do_reset();
        in_valid = 1; sen[0] = 1; sa[0] = 6; fv[1] = 1; fp[1] = 1; fa[1] = 6;
        repeat (4) cycle();
        fv[1] = 0;
        cycle();
        in_valid = 0; flush = 1;
        cycle();
        flush = 0;
`ifdef ID_PERF_CNT_EN
        chk("perf_stall4", perf_stall_cnt, 64'd4);
        chk("perf_flush1", perf_flush_cnt, 64'd1);
`endif
        do_reset();

        // Asynchronous reset mid-operation
        in_valid = 1; sen[0] = 0; in_imm = 32'h99;
        cycle();
        #2;
        rst = 0;
        #1;
        chk("async_rst", out_valid, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom % 4) != 0;
            in_op       = OW'($urandom);
            in_imm      = $urandom;
            in_dst_en   = $urandom % 2;
            in_dst_addr = AW'($urandom);
            flush       = ($urandom % 16) == 0;
            out_ready   = ($urandom % 4) != 0;
            for (int k = 0; k < 2; k++) begin
                sen[k] = $urandom % 4 != 0; sa[k] = $urandom_range(0, 7); rf[k] = $urandom;
            end
            for (int i = 0; i < NF; i++) begin
                fv[i] = $urandom % 2; fp[i] = ($urandom % 4) == 0;
                fa[i] = $urandom_range(0, 7); fd[i] = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
